cs_out_buf: RTL and testbench

- Output collector directly downstream of the 9-tap approximate-average smoother.
- Samples the smoother's 10-bit Y result on every clock and discards warm-up results until the 9-sample window holds only live data.
- Pushes valid results into a first-word-fall-through FIFO and drains them over a valid/ready handshake to the result sink.
- Flags overflow and reports fill level.

---
 rtl/cs_out_buf.sv | 87 ++++++++
 tb/tb_cs_out_buf.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_out_buf.sv
// rtl/cs_out_buf.sv - FWFT output collector for the 9-tap smoother; optional peak via CS_OUT_PEAK_EN
module cs_out_buf #(
    parameter int DEPTH = 16,
    parameter int WIN   = 9,
    parameter int LW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_vld,
    input  logic [9:0]    y,
    input  logic          clr,
    output logic [9:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          full,
    output logic          ovf,
    output logic [LW-1:0] level
`ifdef CS_OUT_PEAK_EN
    ,
    output logic [9:0]    peak
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIN + 1);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          vld_d;
    logic [CW-1:0] win_cnt;
    logic          push;
    logic          pop;
    logic          wr_en;

    // y at this edge belongs to the X flagged by vld_d, so vld_d gates everything
    assign push      = vld_d && (win_cnt >= CW'(WIN - 1));
    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            vld_d   <= 1'b0;
            win_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf     <= 1'b0;
        end else begin
            vld_d <= in_vld;
            if (!vld_d)
                win_cnt <= '0;
            else if (win_cnt != CW'(WIN))
                win_cnt <= win_cnt + CW'(1);
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && full && !pop)
                ovf <= 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset && !clr)
            mem[wr_ptr] <= y;
    end

`ifdef CS_OUT_PEAK_EN
    // Dropped samples still count toward the peak; clr leaves it alone
    always_ff @(posedge clk) begin
        if (reset)
            peak <= '0;
        else if (push && !clr && (y > peak))
            peak <= y;
    end
`endif

endmodule

// File: tb/tb_cs_out_buf.sv
// tb/tb_cs_out_buf.sv - scoreboard bench for cs_out_buf
module tb_cs_out_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_vld = 1'b0;
    logic [9:0] y = '0;
    logic       clr = 1'b0;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       full;
    logic       ovf;
    logic [4:0] level;
`ifdef CS_OUT_PEAK_EN
    logic [9:0] peak;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [9:0] prev_x = '0;
    logic [9:0] exp_q[$];

    cs_out_buf #(.DEPTH(16), .WIN(9), .LW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .y         (y),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .ovf       (ovf),
        .level     (level)
`ifdef CS_OUT_PEAK_EN
        ,
        .peak      (peak)
`endif
    );

    always #5 clk = ~clk;

    // Every accepted word must be the oldest expected one
    always @(negedge clk) begin
        if (!reset && !clr && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got %0d required none", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_data got %0d required %0d", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle: X=val is live this cycle, y carries the result of last cycle's X
    task automatic cycle(input logic v, input logic [9:0] val);
        in_vld = v;
        y      = prev_x;
        prev_x = val;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_vld = 1'b0; clr = 1'b0; out_ready = 1'b0; y = '0; prev_x = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle(1'b0, 10'd0);
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || level !== 5'd0) begin
            errors++;
            $display("FAIL drain_empty got left=%0d level=%0d required 0 0", exp_q.size(), level);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, full, ovf, level, out_data} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state got v=%0b f=%0b o=%0b l=%0d d=%0d required all 0",
                     out_valid, full, ovf, level, out_data);
        end
    endtask

    task automatic test_window();
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 10'(100 + i));
        exp_q.push_back(10'd108);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL window_early got out_valid=%0b required 0", out_valid);
        end
        cycle(1'b0, 10'd0);
        checks++;
        if (out_valid !== 1'b1 || level !== 5'd1 || out_data !== 10'd108) begin
            errors++;
            $display("FAIL window_first got v=%0b l=%0d d=%0d required 1 1 108",
                     out_valid, level, out_data);
        end
        drain(3);
    endtask

    task automatic test_gap();
        int seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 19; i++) begin
            cycle(i != 8 && i < 17, 10'(i));
            if (out_valid !== 1'b0 || level !== 5'd0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL gap_no_push got %0d cycles with data required 0", seen);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, 10'(500 + i));
            if (i >= 8 && i < 24) exp_q.push_back(10'(500 + i));
        end
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got f=%0b l=%0d o=%0b required 1 16 0", full, level, ovf);
        end
        cycle(1'b0, 10'd0);
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got f=%0b l=%0d o=%0b required 1 16 1", full, level, ovf);
        end
        drain(18);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %0b required 1", ovf);
        end
    endtask

    task automatic test_full_wrap();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 44; i++) begin
            out_ready = (i >= 25);
            cycle(1'b1, 10'(300 + i));
            if (i >= 8) exp_q.push_back(10'(300 + i));
            if (i >= 25 && (level !== 5'd16 || ovf !== 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_push_pop got %0d bad cycles required 0", bad);
        end
        drain(20);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_no_ovf got %0b required 0", ovf);
        end
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, 10'(50 + i));
            if (i >= 8 && i < 24) exp_q.push_back(10'(50 + i));
        end
        cycle(1'b0, 10'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) cycle(1'b0, 10'd0);
        out_ready = 1'b0;
        checks++;
        if (level !== 5'd5 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup got l=%0d o=%0b required 5 1", level, ovf);
        end
        clr = 1'b1;
        cycle(1'b0, 10'd0);
        clr = 1'b0;
        exp_q.delete();
        checks++;
        if (level !== 5'd0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_state got l=%0d o=%0b v=%0b required 0 0 0", level, ovf, out_valid);
        end
        for (int i = 0; i < 9; i++) cycle(1'b1, 10'(700 + i));
        checks++;
        if (level !== 5'd0) begin
            errors++;
            $display("FAIL clr_window got level=%0d required 0", level);
        end
        exp_q.push_back(10'd708);
        cycle(1'b0, 10'd0);
        checks++;
        if (level !== 5'd1 || out_data !== 10'd708) begin
            errors++;
            $display("FAIL clr_repush got l=%0d d=%0d required 1 708", level, out_data);
        end
        drain(2);
    endtask

`ifdef CS_OUT_PEAK_EN
    task automatic test_peak();
        logic [9:0] xs [11];
        do_reset();
        for (int i = 0; i < 8; i++) xs[i] = 10'd1000;
        xs[8] = 10'd300; xs[9] = 10'd1023; xs[10] = 10'd12;
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, xs[i]);
            if (i >= 8) exp_q.push_back(xs[i]);
            if (i == 9) begin
                checks++;
                if (peak !== 10'd300) begin
                    errors++;
                    $display("FAIL peak_first got %0d required 300", peak);
                end
            end
        end
        cycle(1'b0, 10'd0);
        checks++;
        if (peak !== 10'd1023) begin
            errors++;
            $display("FAIL peak_max got %0d required 1023", peak);
        end
        clr = 1'b1;
        cycle(1'b0, 10'd0);
        clr = 1'b0;
        exp_q.delete();
        checks++;
        if (peak !== 10'd1023) begin
            errors++;
            $display("FAIL peak_clr got %0d required 1023", peak);
        end
        do_reset();
        checks++;
        if (peak !== 10'd0) begin
            errors++;
            $display("FAIL peak_reset got %0d required 0", peak);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_window();
        test_gap();
        test_overflow();
        test_full_wrap();
        test_clr();
`ifdef CS_OUT_PEAK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
